uart_rx_cmd_ctrl: RTL and testbench
===================================

# uart_rx_cmd_ctrl

Packet-level controller that sits directly behind the UART byte receiver. It consumes the receiver's `valid`/`byte` output and frames bytes into fixed 5-byte command packets, checking sync, checksum and command. It issues single-cycle register-write or clear strobes to downstream logic and aborts stalled packets with an inter-byte timeout.

## Interface
- `TIMEOUT_CYCLES`, default 25000: allowed idle clocks between bytes inside a packet. Minimum 2.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_rx_valid`  in  1  receiver byte-valid; may stay high for many cycles per byte.
- `i_rx_byte`  in  8  receiver byte; stable while `i_rx_valid` is high.
- `o_wr_en`  out  1  one-cycle write strobe.
- `o_wr_addr`  out  4  write address; held until the next write.
- `o_wr_data`  out  8  write data; held until the next write.
- `o_clr`  out  1  one-cycle clear-all strobe.
- `o_err`  out  1  one-cycle error strobe.
- `o_err_code`  out  2  error code; valid with `o_err`, held afterwards.
  - 1: checksum mismatch.
  - 2: bad command or address.
  - 3: timeout.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Byte acceptance**
  - A byte is accepted only on the rising edge of `i_rx_valid`, i.e. `i_rx_valid`=1 and the registered previous value =0.
  - A high level that continues is never re-accepted.
  - The registered previous value resets to 1, so a `valid` already high at reset release is ignored.
- **Packet format:** SYNC=0xA5, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
- **Commands**
  - 0x57 ('W'): write DATA to ADDR[3:0]. ADDR[7:4] must be 0.
  - 0x43 ('C'): clear. ADDR and DATA are ignored but still covered by the checksum.
- **States:** IDLE, CMD, ADDR, DATA, CHK.
  - IDLE: an accepted byte of 0xA5 moves to CMD. Any other byte is discarded silently, with no error.
  - CMD, ADDR, DATA: latch the accepted byte into an internal register and advance to the next state.
  - CHK: an accepted byte always returns the FSM to IDLE. The result is decided in this priority order:
    - checksum mismatch -> `o_err`, code 1;
    - else CMD not in {0x57, 0x43}, or CMD=0x57 with ADDR[7:4]≠0 -> `o_err`, code 2;
    - else 0x57 -> `o_wr_en`, loading `o_wr_addr`=ADDR[3:0] and `o_wr_data`=DATA;
    - else 0x43 -> `o_clr`.
- **Timeout**
  - A counter of width `$clog2(TIMEOUT_CYCLES)` clears on entry to CMD and on every accepted byte. It increments every cycle in a non-IDLE state.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle, the FSM returns to IDLE and pulses `o_err` with code 3.
  - If a byte is accepted in that same cycle, the byte wins and no timeout occurs.
- Exactly one of `o_wr_en`, `o_clr`, `o_err` pulses per completed or aborted packet. They are never high simultaneously.
- **Reset (also mid-packet)**
  - FSM returns to IDLE, counter goes to 0, latched bytes are cleared.
  - All outputs reset to 0, including `o_wr_addr`, `o_wr_data` and `o_err_code`.

## Timing
- All outputs are registered.
- If the CHK byte is accepted in cycle N:
  - the strobe and its code/addr/data are high/valid in cycle N+1 only;
  - `o_busy` is 0 from cycle N+1.
- A SYNC byte whose acceptance cycle is N+1 is processed normally, so back-to-back packets need no gap.
- `o_busy` rises in the cycle after SYNC is accepted.
- A timeout detected in cycle T gives `o_err` high in T+1 and `o_busy` low in T+1.
- Latency from SYNC acceptance to timeout error with no further bytes: `o_err` high TIMEOUT_CYCLES+1 cycles after the cycle SYNC was accepted.

## Test plan
- **Valid write:** bytes A5 57 03 5A 0E, with `i_rx_valid` high 107 cycles per byte -> one `o_wr_en` pulse, addr=3, data=0x5A; `o_err` and `o_clr` stay 0.
- **Bad checksum / bad address:**
  - A5 57 03 5A 0F -> `o_err` with code 1, no `o_wr_en`.
  - A5 57 13 5A 1E -> `o_err` with code 2.
- **Clear and bad command:**
  - A5 43 00 00 43 -> one `o_clr` pulse; `o_wr_addr` and `o_wr_data` keep their previous values.
  - A5 10 00 00 10 -> code 2.
- **Timeout:** with TIMEOUT_CYCLES=50, send A5 57, then silence -> `o_err` code 3 exactly 51 cycles after the 0x57 acceptance cycle. A byte arriving on the expiry cycle instead suppresses the error.
- **Garbage and back-to-back:** 00 FF A5 followed by a valid write, then an immediate second valid write -> exactly two `o_wr_en` pulses, correct addr/data for each.
- **Reset:**
  - Assert `i_rst` after A5 57 03 -> all outputs 0, `o_busy` 0.
  - Release reset with `i_rx_valid` already high -> no byte accepted.
  - A following full packet executes normally.

Source files
------------

// File: rtl/uart_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd_ctrl
//   Packet-level controller that sits behind a UART byte receiver. It frames
//   received bytes into fixed 5-byte packets: SYNC(0xA5), CMD, ADDR, DATA, CHK.
//   CHK must equal CMD ^ ADDR ^ DATA. A valid packet produces a single-cycle
//   write or clear strobe. A bad checksum, a bad command/address, or an
//   inter-byte timeout produces a single-cycle error strobe with a code.
//
// Parameters
//   TIMEOUT_CYCLES : idle clocks allowed between bytes inside a packet (>= 2)
//
// Ports
//   i_clk        in   system clock
//   i_rst        in   synchronous active-high reset
//   i_rx_valid   in   receiver byte-valid (level; only its rising edge counts)
//   i_rx_byte    in   receiver byte, stable while i_rx_valid is high
//   o_wr_en      out  one-cycle write strobe
//   o_wr_addr    out  write address, held until the next write
//   o_wr_data    out  write data, held until the next write
//   o_clr        out  one-cycle clear-all strobe
//   o_err        out  one-cycle error strobe
//   o_err_code   out  1 = checksum, 2 = command/address, 3 = timeout (held)
//   o_busy       out  high while a packet is in progress
// -----------------------------------------------------------------------------
module uart_rx_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_wr_en,
  output logic [3:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_clr,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_CLEAR = 8'h43;

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_CMD = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  // Packet checksum: XOR of the three payload bytes.
  function automatic logic [7:0] calc_chk(input logic [7:0] cmd,
                                          input logic [7:0] addr,
                                          input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

  // Clear is always legal; write only targets the 16-entry space.
  function automatic logic cmd_is_legal(input logic [7:0] cmd,
                                        input logic [7:0] addr);
    return (cmd == CMD_CLEAR) || ((cmd == CMD_WRITE) && (addr[7:4] == 4'h0));
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             rx_valid_prev_r;
  logic             accept_s;
  logic [7:0]       cmd_r;
  logic [7:0]       addr_r;
  logic [7:0]       data_r;
  logic [CNT_W-1:0] tmo_cnt_r;
  logic [CNT_W-1:0] tmo_cnt_nxt_s;

  logic             wr_en_r;
  logic [3:0]       wr_addr_r;
  logic [7:0]       wr_data_r;
  logic             clr_r;
  logic             err_r;
  logic [1:0]       err_code_r;
  logic             busy_r;

  logic             wr_en_nxt_s;
  logic [3:0]       wr_addr_nxt_s;
  logic [7:0]       wr_data_nxt_s;
  logic             clr_nxt_s;
  logic             err_nxt_s;
  logic [1:0]       err_code_nxt_s;

  // Only the rising edge of valid delivers a byte; prev resets high so a
  // valid already asserted at reset release is ignored.
  assign accept_s = i_rx_valid & ~rx_valid_prev_r;

  // Edge-detect register for the receiver valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_valid_prev_r <= 1'b1;
    end else begin
      rx_valid_prev_r <= i_rx_valid;
    end
  end

  // Next-state and strobe decode; an accepted byte always beats a timeout.
  always_comb begin
    state_nxt_s    = state_r;
    wr_en_nxt_s    = 1'b0;
    clr_nxt_s      = 1'b0;
    err_nxt_s      = 1'b0;
    err_code_nxt_s = err_code_r;
    wr_addr_nxt_s  = wr_addr_r;
    wr_data_nxt_s  = wr_data_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (i_rx_byte == SYNC_BYTE)) begin
          state_nxt_s = ST_CMD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CMD, ST_ADDR, ST_DATA, ST_CHK: begin
        if (accept_s) begin
          case (state_r)
            ST_CMD:  state_nxt_s = ST_ADDR;
            ST_ADDR: state_nxt_s = ST_DATA;
            ST_DATA: state_nxt_s = ST_CHK;
            default: begin
              // CHK byte: checksum first, then legality, then execute.
              state_nxt_s = ST_IDLE;
              if (calc_chk(cmd_r, addr_r, data_r) != i_rx_byte) begin
                err_nxt_s      = 1'b1;
                err_code_nxt_s = ERR_CHK;
              end else if (!cmd_is_legal(cmd_r, addr_r)) begin
                err_nxt_s      = 1'b1;
                err_code_nxt_s = ERR_CMD;
              end else if (cmd_r == CMD_WRITE) begin
                wr_en_nxt_s   = 1'b1;
                wr_addr_nxt_s = addr_r[3:0];
                wr_data_nxt_s = data_r;
              end else begin
                clr_nxt_s = 1'b1;
              end
            end
          endcase
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s    = ST_IDLE;
          err_nxt_s      = 1'b1;
          err_code_nxt_s = ERR_TMO;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Inter-byte counter: zero in IDLE, on every accepted byte and on any
  // return to IDLE; otherwise counts idle clocks.
  always_comb begin
    if ((state_r == ST_IDLE) || accept_s || (state_nxt_s == ST_IDLE)) begin
      tmo_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1);
    end
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end

  // Capture CMD/ADDR/DATA bytes as they are accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_r  <= 8'h00;
      addr_r <= 8'h00;
      data_r <= 8'h00;
    end else if (accept_s) begin
      case (state_r)
        ST_CMD:  cmd_r  <= i_rx_byte;
        ST_ADDR: addr_r <= i_rx_byte;
        ST_DATA: data_r <= i_rx_byte;
        default: cmd_r  <= cmd_r;
      endcase
    end else begin
      cmd_r <= cmd_r;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_en_r    <= 1'b0;
      wr_addr_r  <= 4'h0;
      wr_data_r  <= 8'h00;
      clr_r      <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 2'd0;
      busy_r     <= 1'b0;
    end else begin
      wr_en_r    <= wr_en_nxt_s;
      wr_addr_r  <= wr_addr_nxt_s;
      wr_data_r  <= wr_data_nxt_s;
      clr_r      <= clr_nxt_s;
      err_r      <= err_nxt_s;
      err_code_r <= err_code_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  assign o_wr_en    = wr_en_r;
  assign o_wr_addr  = wr_addr_r;
  assign o_wr_data  = wr_data_r;
  assign o_clr      = clr_r;
  assign o_err      = err_r;
  assign o_err_code = err_code_r;
  assign o_busy     = busy_r;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cmd_ctrl
//   Self-checking bench for uart_rx_cmd_ctrl. u_dut uses a short timeout (50)
//   for the bulk of the checks; u_long keeps the default timeout so that a
//   packet with very long valid pulses can be exercised. Expected strobes come
//   from a byte-stream parser model that works on whole packets.
// -----------------------------------------------------------------------------
module tb_uart_rx_cmd_ctrl;

  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;

  logic       wr_en, clr, err, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] err_code;

  logic       wr_en_l, clr_l, err_l, busy_l;
  logic [3:0] wr_addr_l;
  logic [7:0] wr_data_l;
  logic [1:0] err_code_l;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;
  int wr_cnt_l = 0;
  int clr_cnt_l = 0;
  int err_cnt_l = 0;

  // Event encoding: {kind[1:0], code[1:0], addr[3:0], data[7:0]}
  // kind 1 = write, 2 = clear, 3 = error.
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  stream_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cmd_ctrl #(.TIMEOUT_CYCLES(TMO)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_clr(clr),
    .o_err(err), .o_err_code(err_code), .o_busy(busy)
  );

  uart_rx_cmd_ctrl u_long (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_wr_en(wr_en_l), .o_wr_addr(wr_addr_l), .o_wr_data(wr_data_l), .o_clr(clr_l),
    .o_err(err_l), .o_err_code(err_code_l), .o_busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    check("exclusive", {31'd0, (32'($countones({wr_en, clr, err})) > 32'd1)}, 32'd0);
    check("exclusive_l", {31'd0, (32'($countones({wr_en_l, clr_l, err_l})) > 32'd1)}, 32'd0);
    if (wr_en) obs_q.push_back({2'd1, 2'd0, wr_addr, wr_data});
    if (clr)   obs_q.push_back({2'd2, 2'd0, 4'd0, 8'd0});
    if (err)   obs_q.push_back({2'd3, err_code, 4'd0, 8'd0});
    if (wr_en_l) wr_cnt_l++;
    if (clr_l)   clr_cnt_l++;
    if (err_l)   err_cnt_l++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte: valid high for hold cycles, then low for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_byte      = b;
    rx_valid     = 1'b1;
    last_acc_cyc = cyc;
    tick(hold);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  // Reference model: scan the byte stream, skip non-SYNC bytes in idle,
  // take the next four bytes as a packet; a trailing partial packet times out.
  task automatic build_expect();
    int i;
    logic [7:0] c, a, d, k;
    exp_q.delete();
    i = 0;
    while (i < stream_q.size()) begin
      if (stream_q[i] != 8'hA5) begin
        i++;
      end else if (i + 4 < stream_q.size()) begin
        c = stream_q[i+1]; a = stream_q[i+2]; d = stream_q[i+3]; k = stream_q[i+4];
        if ((c ^ a ^ d) != k)
          exp_q.push_back({2'd3, 2'd1, 4'd0, 8'd0});
        else if (c == 8'h43)
          exp_q.push_back({2'd2, 2'd0, 4'd0, 8'd0});
        else if (c == 8'h57 && a < 8'h10)
          exp_q.push_back({2'd1, 2'd0, a[3:0], d});
        else
          exp_q.push_back({2'd3, 2'd2, 4'd0, 8'd0});
        i += 5;
      end else begin
        exp_q.push_back({2'd3, 2'd3, 4'd0, 8'd0});
        i = stream_q.size();
      end
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_ev%0d", tag, i), {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
  endtask

  // Send stream_q with fixed or random pacing, let any timeout expire, compare.
  task automatic run_stream(input string tag, input int hold, input int gap, input bit rnd);
    int h, g;
    obs_q.delete();
    foreach (stream_q[i]) begin
      h = rnd ? int'($urandom_range(6, 1)) : hold;
      g = rnd ? int'($urandom_range(6, 1)) : gap;
      send_byte(stream_q[i], h, g);
    end
    tick(60);
    build_expect();
    compare_events(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_clr"}, {31'd0, clr}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int a_cyc;
    int found;
    int ng, np, typ;
    logic [7:0] c, a, d, k;

    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    tick(3);
    check_all_zero("reset");
    check("reset_busy_l", {31'd0, busy_l}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Long valid pulses on the default-timeout instance.
    stream_q = '{8'hA5, 8'h57, 8'h03, 8'h5A, 8'h0E};
    foreach (stream_q[i]) send_byte(stream_q[i], 107, 3);
    tick(5);
    check("long_wr_cnt", wr_cnt_l, 1);
    check("long_clr_cnt", clr_cnt_l, 0);
    check("long_err_cnt", err_cnt_l, 0);
    check("long_wr_addr", {28'd0, wr_addr_l}, 32'h3);
    check("long_wr_data", {24'd0, wr_data_l}, 32'h5A);

    stream_q = '{8'hA5, 8'h57, 8'h03, 8'h5A, 8'h0E};
    run_stream("write", 3, 2, 1'b0);
    check("write_addr", {28'd0, wr_addr}, 32'h3);
    check("write_data", {24'd0, wr_data}, 32'h5A);

    stream_q = '{8'hA5, 8'h57, 8'h03, 8'h5A, 8'h0F};
    run_stream("badchk", 3, 2, 1'b0);
    stream_q = '{8'hA5, 8'h57, 8'h13, 8'h5A, 8'h1E};
    run_stream("badaddr", 3, 2, 1'b0);
    stream_q = '{8'hA5, 8'h43, 8'h00, 8'h00, 8'h43};
    run_stream("clear", 3, 2, 1'b0);
    check("clear_hold_addr", {28'd0, wr_addr}, 32'h3);
    check("clear_hold_data", {24'd0, wr_data}, 32'h5A);
    stream_q = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h10};
    run_stream("badcmd", 3, 2, 1'b0);

    // Timeout latency measured from the CMD byte acceptance cycle.
    obs_q.delete();
    send_byte(8'hA5, 2, 2);
    send_byte(8'h57, 2, 1);
    a_cyc = last_acc_cyc;
    check("tmo_busy_before", {31'd0, busy}, 32'd1);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err) begin
        found = 1;
        break;
      end
    end
    check("tmo_seen", found, 1);
    check("tmo_latency", cyc - a_cyc, TMO + 1);
    check("tmo_code", {30'd0, err_code}, 32'd3);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("tmo_pulse_width", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;

    // Byte arriving exactly on the expiry cycle wins.
    stream_q = '{8'hA5, 8'h57, 8'h03, 8'h5A, 8'h0E};
    obs_q.delete();
    send_byte(8'hA5, 2, 2);
    send_byte(8'h57, 2, TMO - 2);
    send_byte(8'h03, 2, 2);
    send_byte(8'h5A, 2, 2);
    send_byte(8'h0E, 2, 2);
    tick(60);
    build_expect();
    compare_events("expiry");

    // Garbage then two back-to-back writes at the fastest valid pacing.
    stream_q = '{8'h00, 8'hFF, 8'hA5, 8'h57, 8'h07, 8'hC3, 8'h93,
                 8'hA5, 8'h57, 8'h0C, 8'h3E, 8'h65};
    run_stream("b2b", 1, 1, 1'b0);
    check("b2b_addr", {28'd0, wr_addr}, 32'hC);
    check("b2b_data", {24'd0, wr_data}, 32'h3E);

    // Reset mid-packet, released with valid already high.
    send_byte(8'hA5, 2, 2);
    send_byte(8'h57, 2, 2);
    send_byte(8'h03, 2, 2);
    check("midpkt_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; rx_byte = 8'hA5; rx_valid = 1'b1;
    tick(2);
    check_all_zero("midrst");
    rst = 1'b0;
    tick(4);
    check("rst_release_busy", {31'd0, busy}, 32'd0);
    rx_valid = 1'b0;
    tick(2);
    stream_q = '{8'hA5, 8'h57, 8'h09, 8'h77, 8'h29};
    run_stream("after_rst", 2, 2, 1'b0);

    // Randomized streams of garbage and mixed packets.
    for (int it = 0; it < 15; it++) begin
      stream_q.delete();
      ng = int'($urandom_range(2, 0));
      for (int j = 0; j < ng; j++) stream_q.push_back(8'($urandom_range(255, 0)));
      np = int'($urandom_range(3, 1));
      for (int j = 0; j < np; j++) begin
        typ = int'($urandom_range(3, 0));
        d = 8'($urandom_range(255, 0));
        case (typ)
          0: begin c = 8'h57; a = {4'h0, 4'($urandom_range(15, 0))}; k = c ^ a ^ d; end
          1: begin c = 8'h43; a = 8'($urandom_range(255, 0)); k = c ^ a ^ d; end
          2: begin
            c = ($urandom_range(1, 0) == 0) ? 8'h57 : 8'h43;
            a = {4'h0, 4'($urandom_range(15, 0))};
            k = c ^ a ^ d ^ 8'($urandom_range(255, 1));
          end
          default: begin
            if ($urandom_range(1, 0) == 0) begin
              c = 8'h57; a = {4'($urandom_range(15, 1)), 4'($urandom_range(15, 0))};
            end else begin
              c = 8'($urandom_range(255, 0));
              if (c == 8'h57 || c == 8'h43) c = 8'h00;
              a = 8'($urandom_range(255, 0));
            end
            k = c ^ a ^ d;
          end
        endcase
        stream_q.push_back(8'hA5);
        stream_q.push_back(c);
        stream_q.push_back(a);
        stream_q.push_back(d);
        stream_q.push_back(k);
      end
      if ($urandom_range(4, 0) == 0) begin
        for (int j = int'($urandom_range(3, 1)); j > 0; j--) void'(stream_q.pop_back());
      end
      run_stream($sformatf("rand%0d", it), 0, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
